// File: rtl/mem_read_arbiter_pkg.sv
// mem_read_arbiter_pkg: shared line-geometry constants and arbiter state type
package mem_read_arbiter_pkg;
  localparam int DCACHE_LINE_SIZE = 16;
  localparam int DCACHE_LINE_OFFSET = 4;
  localparam int LINE_BITS = DCACHE_LINE_SIZE * 8;
  localparam int LINE_OFFSET = DCACHE_LINE_OFFSET;
  typedef enum logic [0:0] {ARB_IDLE = 1'b0, ARB_WAIT = 1'b1} arb_state_t;
endpackage

// File: rtl/mem_read_arbiter_rr_pick.sv
// rr_pick: first set bit of pending at or after ptr, wrapping
module rr_pick #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);
  // scan from the farthest offset back to ptr so the closest pending index wins
  always_comb begin
    winner = '0;
    any_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pending[(int'(ptr) + k) % N]) begin
        winner = IW'((int'(ptr) + k) % N);
        any_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one line-refill read channel with same-line merging
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_OFFSET = mem_read_arbiter_pkg::LINE_OFFSET,
  parameter int LINE_BITS = mem_read_arbiter_pkg::LINE_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [LINE_BITS-1:0]          resp_data,
  output logic                          mem_req_valid,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [LINE_BITS-1:0]          mem_resp_data
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << LINE_OFFSET) - ADDR_WIDTH'(1));
  arb_state_t state;
  logic [NUM_REQ-1:0] pending, merged, match, done, avail;
  logic [ADDR_WIDTH-1:0] pend_addr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] req_line [NUM_REQ];
  logic [IW-1:0] grant, rr_ptr, winner;
  logic any_valid;
  assign avail = pending & ~merged;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .pending  (avail),
    .ptr      (rr_ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );
  // line-align incoming addresses and find requesters that can ride on the in-flight line
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_line[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & LINE_MASK;
      match[i] = state == ARB_WAIT && IW'(i) != grant &&
                 (pending[i] ? pend_addr[i] == pend_addr[grant]
                             : req_valid[i] && req_line[i] == pend_addr[grant]);
    end
    done = (state == ARB_WAIT && mem_resp_valid) ? ((NUM_REQ'(1) << grant) | merged | match) : '0;
    resp_valid = done;
    resp_data = |done ? mem_resp_data : '0;
    mem_req_valid = state == ARB_IDLE && any_valid;
    mem_req_addr = mem_req_valid ? pend_addr[winner] : '0;
  end
  // request latching, merge tracking, grant issue and completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      pending <= '0;
      merged <= '0;
      grant <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) pend_addr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i]) pending[i] <= 1'b0;
        else if (req_valid[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          pend_addr[i] <= req_line[i];
        end
      end
      merged <= (merged | match) & ~done;
      if (mem_req_valid) begin
        state <= ARB_WAIT;
        grant <= winner;
        rr_ptr <= winner == IW'(NUM_REQ - 1) ? '0 : winner + IW'(1);
      end else if (state == ARB_WAIT && mem_resp_valid) state <= ARB_IDLE;
    end
  end
endmodule
